// File: rtl/alu_decode_stage.sv
// ID/EX ALU-operation decoder: turns a MIPS instruction word into registered ALU controls
// for the EX stage, with valid/stall/flush slot handling and a saturating illegal-op count.
module alu_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic        flush,
    output logic        in_ready,
    output logic        ex_valid,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  shamt,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [31:0] imm_ext,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    typedef enum logic [3:0] {
        ALU_NOP  = 4'b0000,
        ALU_ADD  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SUB  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_LESS = 4'b1000,
        ALU_NOR  = 4'b1001,
        ALU_SLLV = 4'b1010,
        ALU_SRLV = 4'b1011,
        ALU_SRAV = 4'b1100,
        ALU_XOR  = 4'b1101
    } alu_code_t;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] sign_imm;
    logic [31:0] zero_imm;

    alu_code_t   d_ctrl;
    logic [4:0]  d_shamt;
    logic [1:0]  d_a_sel;
    logic        d_b_sel;
    logic [31:0] d_imm;
    logic        d_illegal;

    assign op       = instr[31:26];
    assign funct    = instr[5:0];
    assign sign_imm = {{16{instr[15]}}, instr[15:0]};
    assign zero_imm = {16'b0, instr[15:0]};
    assign in_ready = ~stall;

    always_comb begin
        d_ctrl    = ALU_NOP;
        d_shamt   = 5'd0;
        d_a_sel   = 2'b00;
        d_b_sel   = 1'b0;
        d_imm     = 32'd0;
        d_illegal = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100001: d_ctrl = ALU_ADD;
                    6'b100010, 6'b100011: d_ctrl = ALU_SUB;
                    6'b100100:            d_ctrl = ALU_AND;
                    6'b100101:            d_ctrl = ALU_OR;
                    6'b100110:            d_ctrl = ALU_XOR;
                    6'b100111:            d_ctrl = ALU_NOR;
                    6'b101010:            d_ctrl = ALU_LESS;
                    6'b000000: begin d_ctrl = ALU_SLL; d_a_sel = 2'b01; d_shamt = instr[10:6]; end
                    6'b000010: begin d_ctrl = ALU_SRL; d_a_sel = 2'b01; d_shamt = instr[10:6]; end
                    6'b000011: begin d_ctrl = ALU_SRA; d_a_sel = 2'b01; d_shamt = instr[10:6]; end
                    // Variable shifts take the amount from rs on in2; the EX mux swaps it in.
                    6'b000100: begin d_ctrl = ALU_SLLV; d_a_sel = 2'b01; end
                    6'b000110: begin d_ctrl = ALU_SRLV; d_a_sel = 2'b01; end
                    6'b000111: begin d_ctrl = ALU_SRAV; d_a_sel = 2'b01; end
                    6'b001000:            d_ctrl = ALU_NOP;
                    default:              d_illegal = 1'b1;
                endcase
            end
            6'b001000, 6'b001001,
            6'b100011, 6'b101011: begin d_ctrl = ALU_ADD;  d_b_sel = 1'b1; d_imm = sign_imm; end
            6'b001010:            begin d_ctrl = ALU_LESS; d_b_sel = 1'b1; d_imm = sign_imm; end
            6'b001100:            begin d_ctrl = ALU_AND;  d_b_sel = 1'b1; d_imm = zero_imm; end
            6'b001101:            begin d_ctrl = ALU_OR;   d_b_sel = 1'b1; d_imm = zero_imm; end
            6'b001110:            begin d_ctrl = ALU_XOR;  d_b_sel = 1'b1; d_imm = zero_imm; end
            6'b000100, 6'b000101:       d_ctrl = ALU_SUB;
            // lui is the immediate shifted left by 16 on in1.
            6'b001111: begin d_ctrl = ALU_SLL; d_a_sel = 2'b10; d_shamt = 5'd16; d_imm = zero_imm; end
            6'b000010, 6'b000011:       d_ctrl = ALU_NOP;
            default:                    d_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            alu_ctrl    <= 4'd0;
            shamt       <= 5'd0;
            a_sel       <= 2'b00;
            b_sel       <= 1'b0;
            imm_ext     <= 32'd0;
            illegal     <= 1'b0;
            illegal_cnt <= 8'd0;
        end else if (flush || (!stall && !in_valid)) begin
            ex_valid <= 1'b0;
            alu_ctrl <= 4'd0;
            shamt    <= 5'd0;
            a_sel    <= 2'b00;
            b_sel    <= 1'b0;
            imm_ext  <= 32'd0;
            illegal  <= 1'b0;
        end else if (!stall) begin
            ex_valid <= 1'b1;
            alu_ctrl <= d_ctrl;
            shamt    <= d_shamt;
            a_sel    <= d_a_sel;
            b_sel    <= d_b_sel;
            imm_ext  <= d_imm;
            illegal  <= d_illegal;
            if (d_illegal && illegal_cnt != 8'hFF) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered ALU-operation decoder at the ID/EX boundary of the five-stage MIPS pipeline. Takes a 32-bit instruction word from ID and produces, one cycle later, the 4-bit ALU control code, shift amount, operand-source selects and extended immediate consumed by the EX-stage ALU. It is the producing end of the ALUControl/shamt interface. It owns the ID/EX control-register semantics (valid, stall hold, flush bubble) and keeps an illegal-instruction count.

## Interface
- No parameters; data width fixed at 32, control code width fixed at 4.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; 0 on a rising edge clears all state
- in_valid  in  1  instr holds a real instruction
- instr  in  32  MIPS instruction word
- stall  in  1  hold EX-side registers; do not accept instr
- flush  in  1  replace the accepted slot with a bubble
- in_ready  out  1  combinational, = ~stall
- ex_valid  out  1  registered outputs hold a real instruction
- alu_ctrl  out  4  ALU code (encoding below)
- shamt  out  5  constant shift amount
- a_sel  out  2  ALU in1 source: 00 rs, 01 rt, 10 imm_ext
- b_sel  out  1  ALU in2 source: 0 rt (or rs for variable shifts, see below), 1 imm_ext
- imm_ext  out  32  extended immediate
- illegal  out  1  registered instruction was undecodable
- illegal_cnt  out  8  saturating count of accepted illegal instructions

## Operation
- Codes: 0000 NOP, ADD 0001, AND 0010, OR 0011, SUB 0100, SLL 0101, SRL 0110, SRA 0111, LESS 1000, NOR 1001, SLLV 1010, SRLV 1011, SRAV 1100, XOR 1101.
- R-type (op 000000), by funct:
  - add/addu 100000/100001 → ADD
  - sub/subu 100010/100011 → SUB
  - and 100100 → AND
  - or 100101 → OR
  - xor 100110 → XOR
  - nor 100111 → NOR
  - slt 101010 → LESS
  - Register ops: a_sel=00, b_sel=0 (in2=rt), shamt=0.
- Constant shifts (a_sel=01, shamt=instr[10:6]):
  - sll 000000 → SLL
  - srl 000010 → SRL
  - sra 000011 → SRA
- Variable shifts (a_sel=01, b_sel=0 with in2=rs swapped in; shamt=0):
  - sllv 000100 → SLLV
  - srlv 000110 → SRLV
  - srav 000111 → SRAV
- jr 001000 → NOP, legal.
- I-type, all with b_sel=1:
  - addi/addiu 001000/001001 → ADD, sign-extend
  - slti 001010 → LESS, sign-extend
  - andi/ori/xori 001100/001101/001110 → AND/OR/XOR, zero-extend
  - lw 100011 and sw 101011 → ADD, sign-extend
  - beq 000100 and bne 000101 → SUB, b_sel=0 (in2=rt)
- lui 001111 → SLL, a_sel=10, shamt=16, imm zero-extended.
- j 000010 and jal 000011 → NOP, legal.
- Any other op/funct is illegal: alu_ctrl=0000, illegal=1.
- Unused outputs in a decoded slot are 0.
- imm_ext = {{16{instr[15]}},instr[15:0]} when sign-extending, {16'b0,instr[15:0]} when zero-extending, else 0.

## Timing
- Reset (reset=0 at edge): ex_valid=0, alu_ctrl=0, shamt=0, a_sel=0, b_sel=0, imm_ext=0, illegal=0, illegal_cnt=0. Reset dominates all other inputs.
- Latency: an instruction accepted at edge N appears on the outputs after edge N.
- Acceptance: at an edge with reset=1, stall=0 and flush=0, all outputs load the decode of instr, and ex_valid=in_valid.
  - in_valid=0 loads a bubble: all fields 0, illegal=0.
- Stall (stall=1, flush=0): every output holds, including illegal_cnt.
- Flush (flush=1): load a bubble regardless of stall or in_valid; illegal_cnt unchanged.
- Priority: reset > flush > stall > load.
- illegal_cnt increments by 1 only at an accepting edge with in_valid=1 and an illegal decode. It saturates at 255 and clears only on reset.
- illegal output is registered with the slot; it is never set on a bubble.

## Test plan
- Reset: hold reset=0 two cycles with in_valid=1, instr=0x00851020 (add) → all outputs 0. Release → next edge gives ex_valid=1, alu_ctrl=0001, a_sel=00, b_sel=0.
- Immediate decode: addi 0x2084FFFF → alu_ctrl=0001, b_sel=1, imm_ext=0xFFFFFFFF. ori 0x3484FFFF → alu_ctrl=0011, imm_ext=0x0000FFFF. lui 0x3C041234 → alu_ctrl=0101, a_sel=10, shamt=16, imm_ext=0x00001234.
- Shifts: sra 0x00041083 → alu_ctrl=0111, shamt=2, a_sel=01. srav 0x00A41007 → alu_ctrl=1100, a_sel=01, b_sel=0, shamt=0.
- Stall and flush: load add, then apply stall=1 for 3 cycles while instr changes → outputs unchanged. Then stall=1 with flush=1 for one edge → ex_valid=0 and all fields 0.
- Illegal counter: 256 accepted instructions with instr=0xFC000000 → illegal=1, alu_ctrl=0000, illegal_cnt reaches 255 and stays there. One extra illegal under stall leaves it at 255. Reset → 0.
- Mid-stream reset: drive reset=0 during a stalled valid slot → next edge shows ex_valid=0 and illegal_cnt=0.
